irrigation_timer_ctrl: RTL
==========================

# irrigation_timer_ctrl

Countdown controller for the irrigation cycle. It holds a 4-digit BCD MM:SS duration and sequences load, run, pause and expiry. It drives the irrigation valve enable. It also owns the display scan: it generates the digit select that time-multiplexes the four BCD digits onto one shared BCD bus for the seven-segment decoder.

## Interface
- TICK_DIV, 50_000_000: clk cycles per one-second countdown tick (≥2).
- SCAN_DIV, 50_000: clk cycles per display digit step (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  level; when high, capture the preset.
- start  in  1  level; begin or resume the countdown.
- stop  in  1  level; pause the countdown.
- preset_min  in  8  BCD minutes: [7:4] tens, [3:0] ones.
- preset_sec  in  8  BCD seconds: [7:4] tens, [3:0] ones.
- valve  out  1  irrigation valve enable; high only in RUN.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on expiry.
- digit_sel  out  2  scanned digit: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
- anode_n  out  4  active-low one-hot digit enable, equal to ~(1<<digit_sel).
- bcd  out  4  BCD value of the digit selected by digit_sel.

## Operation
- Reset values: state IDLE; count 00:00; valve 0, running 0, done 0; tick and scan prescalers 0; digit_sel 0; anode_n 4'b1110; bcd 0.
- States: IDLE, RUN, PAUSE, DONE.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Copies the clamped preset into count, goes to IDLE and clears the tick prescaler.
  - Clamping: any digit >9 becomes 9; seconds tens >5 becomes 5.
- Transition priority, highest first: reset, stop, load, start.
- IDLE:
  - start with count ≠ 00:00 goes to RUN.
  - start with count = 00:00 is ignored.
- RUN:
  - stop goes to PAUSE; the tick prescaler holds its value.
  - The tick prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1, it wraps to 0 and count decrements by one second.
- PAUSE:
  - start goes to RUN; the prescaler resumes from its held value.
  - load behaves as above.
- Decrement, BCD with borrow chain:
  - sec ones 0→9 with borrow, else −1.
  - sec tens 0→5 with borrow.
  - min ones 0→9 with borrow.
  - min tens −1.
  - 00:00 is never decremented.
- Expiry: the tick that makes count 00:00 moves the state to DONE on that edge. done is high for exactly one cycle after that edge; valve and running fall on the same edge.
- DONE: holds count 00:00. load goes to IDLE; start is ignored, since count is 0.
- Scan:
  - The scan prescaler runs freely in every state, counting 0..SCAN_DIV-1.
  - On wrap, digit_sel increments modulo 4 (3→0).
  - anode_n and bcd are combinational from the registered digit_sel and count, so they never disagree with digit_sel.
- Simultaneous stop+start in RUN or PAUSE: stop wins, state is PAUSE.
- Reset mid-run: valve is 0 on the next edge and count is cleared.

## Timing
- start to valve/running high: 1 cycle (registered).
- stop to valve low: 1 cycle.
- First decrement after start from IDLE: TICK_DIV cycles after entering RUN.
- Digit dwell: SCAN_DIV cycles. Full refresh: 4·SCAN_DIV cycles.
- count change to bcd: visible in the same cycle as the new count, when that digit is selected.
- done: 1 cycle wide, never repeats without a new load and start.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_DIV=2.

1. Reset, then load preset_min=8'h00, preset_sec=8'h03, then start. Required: valve=1 one cycle later; count goes 00:03→00:02→00:01→00:00 at 4-cycle intervals; done pulses once; valve=0 and state DONE.
2. Borrow chain: load 8'h10:8'h00 and run one tick. Required: count 09:59. Then load 8'h00:8'h10 and run one tick. Required: count 00:09.
3. Clamping: load preset_min=8'hAF, preset_sec=8'h7C. Required: count 99:59. Start with count 00:00 after loading 00:00: state stays IDLE and valve stays 0.
4. Pause/resume:
   - Start 00:05 and assert stop at prescaler=2. Required: valve=0 and count frozen for 20 cycles.
   - Assert start. Required: the next decrement occurs 2 cycles later.
   - Assert stop and start together. Required: PAUSE.
   - Assert load during RUN. Required: ignored.
5. Scan: hold count 12:34. Required: digit_sel/anode_n/bcd cycle through (0,1110,4), (1,1101,3), (2,1011,2), (3,0111,1), changing every 2 cycles, and this continues during RUN and PAUSE.
6. Assert rst_n=0 for one cycle mid-RUN. Required: next edge gives valve=0, count 00:00, digit_sel=0, anode_n=1110, done=0.

Source files
------------

// File: rtl/irrigation_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// irrigation_timer_ctrl_if
// Bundles the control inputs and the status/display outputs of the
// irrigation countdown controller.
//   load, start, stop        : level controls from the operator panel
//   preset_min, preset_sec   : BCD MM:SS preset ([7:4] tens, [3:0] ones)
//   valve, running           : high while the countdown is running
//   done                     : one-cycle pulse when the countdown expires
//   digit_sel, anode_n, bcd  : time-multiplexed seven-segment digit scan
// The master modport is the side that drives the controls (panel or bench).
// The slave modport is the controller itself.
// ---------------------------------------------------------------------------
interface irrigation_timer_ctrl_if;
  logic       load;
  logic       start;
  logic       stop;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       valve;
  logic       running;
  logic       done;
  logic [1:0] digit_sel;
  logic [3:0] anode_n;
  logic [3:0] bcd;

  modport master (
    output load, start, stop, preset_min, preset_sec,
    input  valve, running, done, digit_sel, anode_n, bcd
  );

  modport slave (
    input  load, start, stop, preset_min, preset_sec,
    output valve, running, done, digit_sel, anode_n, bcd
  );
endinterface

// File: rtl/irrigation_timer_ctrl.sv
// ---------------------------------------------------------------------------
// irrigation_timer_ctrl
// Countdown controller for one irrigation cycle. It holds a BCD MM:SS
// duration, counts it down once per second while running, and drives the
// valve. It also scans the four count digits onto a shared BCD bus for a
// seven-segment decoder.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : irrigation_timer_ctrl_if.slave (controls, status, display)
// Parameters:
//   TICK_DIV : clk cycles per one-second countdown step (>= 2)
//   SCAN_DIV : clk cycles each display digit is shown (>= 1)
// ---------------------------------------------------------------------------
module irrigation_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input logic                    clk,
  input logic                    rst_n,
  irrigation_timer_ctrl_if.slave bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  // count_q = {min tens, min ones, sec tens, sec ones}
  logic [15:0]       count_q, count_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic              done_q, done_d;

  logic [15:0]       preset_clamped;
  logic [15:0]       count_dec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

  // One-second BCD decrement with borrow through all four digits.
  // Only used while running, where the count is never 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = c;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Out-of-range preset digits saturate so the count is always valid MM:SS.
  assign preset_clamped = {clamp_digit(bus.preset_min[7:4], 4'd9),
                           clamp_digit(bus.preset_min[3:0], 4'd9),
                           clamp_digit(bus.preset_sec[7:4], 4'd5),
                           clamp_digit(bus.preset_sec[3:0], 4'd9)};

  assign count_dec = bcd_dec(count_q);

  // Sequencing of load/run/pause/expiry. Stop outranks load, and load
  // outranks start. While running, stop also pre-empts a pending tick so
  // the prescaler value is kept intact for the resume.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_PAUSE;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          count_d = count_dec;
          // 00:01 is the only value that decrements to 00:00
          if (count_q == 16'h0001) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (!bus.stop) begin
          if (bus.load) begin
            state_d = S_IDLE;
            count_d = preset_clamped;
            tick_d  = '0;
          end else if (bus.start) begin
            state_d = S_RUN;
          end
        end
      end
      S_IDLE, S_DONE: begin
        if (bus.load) begin
          state_d = S_IDLE;
          count_d = preset_clamped;
          tick_d  = '0;
        end else if (bus.start && (count_q != 16'h0000)) begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  // Display scan runs in every state, independent of the countdown.
  always_comb begin
    scan_d  = scan_q;
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= 16'h0000;
      tick_q  <= '0;
      scan_q  <= '0;
      digit_q <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      done_q  <= done_d;
    end
  end

  // Digit mux reads the registered select, so bcd always matches digit_sel.
  always_comb begin
    bus.bcd = count_q[3:0];
    unique case (digit_q)
      2'd0: bus.bcd = count_q[3:0];
      2'd1: bus.bcd = count_q[7:4];
      2'd2: bus.bcd = count_q[11:8];
      2'd3: bus.bcd = count_q[15:12];
    endcase
  end

  assign bus.valve     = (state_q == S_RUN);
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.digit_sel = digit_q;
  assign bus.anode_n   = ~(4'b0001 << digit_q);

endmodule
